// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port-B arbiter.
//   arb_state_t : arbitration FSM states (free arbitration vs. DBG exclusive lock)
//   rd_owner_t  : which master receives dob in the cycle after a granted read
package dmem_port_arbiter_pkg;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } rd_owner_t;

    // A granted access with no byte enables set is a read.
    function automatic logic is_read(input logic gnt, input logic [7:0] we);
        return gnt && (we == '0);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating starvation counter for the DBG master.
//   clk, rst : clock, synchronous active-high reset
//   inc      : DBG requested but was not granted this cycle
//   clr      : DBG granted, DBG not requesting, or port locked
//   sat      : count has reached LIMIT (DBG must win next arbitration)
module arb_starve_ctr #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sat = (cnt == LIM_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing BRAM port B between the CPU MEM stage and a debug/loader master.
// CPU has priority; a starvation counter lets DBG win after STARVE_LIMIT waits.
// DBG may lock the port for bursts, stalling the CPU.
//   cpu_* : CPU request/payload in, grant/stall/read-return out
//   dbg_* : DBG request/lock/payload in, grant/read-return out
//   locked: arbiter is in the LOCKED state
//   addrb/web/dib out, dob in : BRAM port B, one-cycle read latency
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_ARB    | normal arbitration: starved DBG > CPU > DBG
// ST_LOCKED | DBG owns the port exclusively; CPU is never granted
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic [DATA_W/8-1:0] cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_stall,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                dbg_req,
    input  logic                dbg_lock,
    input  logic [DATA_W/8-1:0] dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                locked,
    output logic [ADDR_W-1:0]   addrb,
    output logic [DATA_W/8-1:0] web,
    output logic [DATA_W-1:0]   dib,
    input  logic [DATA_W-1:0]   dob
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state, state_next;
    rd_owner_t  rd_owner;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARB;
        end else begin
            state <= state_next;
        end
    end

    // Grants are suppressed while rst is high so nothing reaches the BRAM.
    always_comb begin
        state_next = state;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_ARB: begin
                    if (dbg_req && starve_sat) begin
                        dbg_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                    if (dbg_gnt && dbg_lock) begin
                        state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    dbg_gnt = dbg_req;
                    if (!dbg_lock) begin
                        state_next = ST_ARB;
                    end
                end
                default: state_next = ST_ARB;
            endcase
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt;
    assign locked    = (state == ST_LOCKED);

    assign starve_inc = dbg_req && !dbg_gnt;
    assign starve_clr = dbg_gnt || !dbg_req || (state == ST_LOCKED);

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk(clk),
        .rst(rst),
        .inc(starve_inc),
        .clr(starve_clr),
        .sat(starve_sat)
    );

    // Idle port presents cpu_addr so the BRAM address does not toggle needlessly.
    always_comb begin
        addrb = cpu_addr;
        web   = '0;
        dib   = '0;
        if (cpu_gnt) begin
            addrb = cpu_addr;
            web   = cpu_we;
            dib   = cpu_wdata;
        end else if (dbg_gnt) begin
            addrb = dbg_addr;
            web   = dbg_we;
            dib   = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else if (is_read(cpu_gnt, 8'(cpu_we))) begin
            rd_owner <= OWN_CPU;
        end else if (is_read(dbg_gnt, 8'(dbg_we))) begin
            rd_owner <= OWN_DBG;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign cpu_rvalid = !rst && (rd_owner == OWN_CPU);
    assign dbg_rvalid = !rst && (rd_owner == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? dob : '0;
    assign dbg_rdata  = dbg_rvalid ? dob : '0;

    // Byte-enable width must fit the read-detect helper.
    if (BE_W > 8) begin : g_be_w_check
        $error("DATA_W/8 must not exceed 8");
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, dbg_req, dbg_lock;
    logic [3:0]  cpu_we, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, locked;
    logic [31:0] cpu_rdata, dbg_rdata, addrb, dib, dob;
    logic [3:0]  web;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .locked(locked), .addrb(addrb), .web(web), .dib(dib), .dob(dob)
    );

    // BRAM port B: read-first, one-cycle latency.
    logic [31:0] bram [0:255];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (web[b]) bram[addrb[9:2]][8*b +: 8] <= dib[8*b +: 8];
        dob <= bram[addrb[9:2]];
    end

    // Reference model state.
    int          m_starve;
    bit          m_locked;
    int          m_rd;          // 0 none, 1 cpu, 2 dbg
    logic [31:0] m_rdat;
    logic [31:0] mmem [0:255];
    logic        e_cg, e_dg;
    logic [31:0] e_addr, e_dib;
    logic [3:0]  e_we;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (m_locked)                           e_dg = dbg_req;
            else if (dbg_req && m_starve == LIM)    e_dg = 1'b1;
            else if (cpu_req)                       e_cg = 1'b1;
            else if (dbg_req)                       e_dg = 1'b1;
        end
        e_addr = e_dg ? dbg_addr  : cpu_addr;
        e_we   = e_cg ? cpu_we    : (e_dg ? dbg_we    : 4'h0);
        e_dib  = e_cg ? cpu_wdata : (e_dg ? dbg_wdata : 32'h0);
    endtask

    task automatic model_check();
        logic crv, drv;
        crv = !rst && m_rd == 1;
        drv = !rst && m_rd == 2;
        chk("m_cpu_gnt",    cpu_gnt,    e_cg);
        chk("m_dbg_gnt",    dbg_gnt,    e_dg);
        chk("m_cpu_stall",  cpu_stall,  cpu_req && !e_cg);
        chk("m_locked",     locked,     m_locked);
        chk("m_cpu_rvalid", cpu_rvalid, crv);
        chk("m_dbg_rvalid", dbg_rvalid, drv);
        chk("m_cpu_rdata",  cpu_rdata,  crv ? m_rdat : 32'h0);
        chk("m_dbg_rdata",  dbg_rdata,  drv ? m_rdat : 32'h0);
        chk("m_addrb",      addrb,      e_addr);
        chk("m_web",        web,        e_we);
        chk("m_dib",        dib,        e_dib);
    endtask

    task automatic model_update();
        int idx;
        idx = int'(e_addr[9:2]);
        if (rst) begin
            m_starve = 0;
            m_locked = 0;
            m_rd     = 0;
        end else begin
            m_rd = 0;
            if (e_cg && cpu_we == 0)      begin m_rd = 1; m_rdat = mmem[idx]; end
            else if (e_dg && dbg_we == 0) begin m_rd = 2; m_rdat = mmem[idx]; end
            for (int b = 0; b < 4; b++)
                if (e_we[b]) mmem[idx][8*b +: 8] = e_dib[8*b +: 8];
            if (m_locked || e_dg || !dbg_req) m_starve = 0;
            else if (m_starve < LIM)          m_starve = m_starve + 1;
            m_locked = m_locked ? dbg_lock : (e_dg && dbg_lock);
        end
    endtask

    task automatic pre();
        @(negedge clk);
        model_eval();
        model_check();
    endtask

    task automatic post();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic dr, input logic dl, input logic [3:0] dw,
                         input logic [31:0] da, input logic [31:0] dd);
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_lock = dl; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    typedef struct {
        logic r, cr; logic [3:0] cw; logic [31:0] ca, cd;
        logic dr, dl; logic [3:0] dw; logic [31:0] da, dd;
        logic ecg, edg, est, elk, ecrv, edrv; logic [31:0] ecrd, edrd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cr, input logic [3:0] cw, input logic [31:0] ca,
                                input logic [31:0] cd, input logic dr, input logic dl, input logic [3:0] dw,
                                input logic [31:0] da, input logic [31:0] dd,
                                input logic ecg, input logic edg, input logic est, input logic elk,
                                input logic ecrv, input logic edrv, input logic [31:0] ecrd, input logic [31:0] edrd);
        vec_t v;
        v.r = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dl = dl; v.dw = dw; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg; v.est = est; v.elk = elk;
        v.ecrv = ecrv; v.edrv = edrv; v.ecrd = ecrd; v.edrd = edrd;
        return v;
    endfunction

    vec_t tbl [14];
    logic [31:0] wd [3];

    initial begin
        for (int i = 0; i < 256; i++) begin
            bram[i] = 32'h0100_0000 * i + 32'h5A5A;
            mmem[i] = 32'h0100_0000 * i + 32'h5A5A;
        end
        bram[8'h10] = 32'hDEAD_BEEF; mmem[8'h10] = 32'hDEAD_BEEF;
        bram[8'h20] = 32'hCAFE_F00D; mmem[8'h20] = 32'hCAFE_F00D;
        bram[8'h21] = 32'h0BAD_C0DE; mmem[8'h21] = 32'h0BAD_C0DE;
        bram[8'h08] = 32'h1122_3344; mmem[8'h08] = 32'h1122_3344;
        m_starve = 0; m_locked = 0; m_rd = 0; m_rdat = 0;

        //           rst req we  addr   wdata   dreq lock dwe daddr  dwdata     cg dg st lk crv drv crd           drd
        tbl[0]  = mk(1, 1, 4'h0, 32'h10,  0,      0, 0, 4'h0, 0,      0,          0, 0, 1, 0, 0, 0, 0,            0);
        tbl[1]  = mk(0, 1, 4'h0, 32'h10,  0,      0, 0, 4'h0, 0,      0,          1, 0, 0, 0, 0, 0, 0,            0);
        tbl[2]  = mk(1, 0, 4'h0, 32'h10,  0,      0, 0, 4'h0, 0,      0,          0, 0, 0, 0, 0, 0, 0,            0);
        tbl[3]  = mk(0, 0, 4'h0, 32'h10,  0,      0, 0, 4'h0, 0,      0,          0, 0, 0, 0, 0, 0, 0,            0);
        tbl[4]  = mk(0, 1, 4'h0, 32'h40,  0,      0, 0, 4'h0, 0,      0,          1, 0, 0, 0, 0, 0, 0,            0);
        tbl[5]  = mk(0, 0, 4'h0, 32'h40,  0,      0, 0, 4'h0, 0,      0,          0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
        tbl[6]  = mk(0, 1, 4'h0, 32'h80,  0,      0, 0, 4'h0, 0,      0,          1, 0, 0, 0, 0, 0, 0,            0);
        tbl[7]  = mk(0, 0, 4'h0, 32'h80,  0,      1, 0, 4'h0, 32'h84, 0,          0, 1, 0, 0, 1, 0, 32'hCAFEF00D, 0);
        tbl[8]  = mk(0, 0, 4'h0, 32'h80,  0,      0, 0, 4'h0, 32'h84, 0,          0, 0, 0, 0, 0, 1, 0,            32'h0BADC0DE);
        tbl[9]  = mk(0, 0, 4'h0, 32'h100, 0,      1, 1, 4'hF, 32'h100, 32'h12345678, 0, 1, 0, 0, 0, 0, 0,          0);
        tbl[10] = mk(0, 1, 4'h0, 32'h100, 0,      0, 1, 4'h0, 0,      0,          0, 0, 1, 1, 0, 0, 0,            0);
        tbl[11] = mk(0, 1, 4'h0, 32'h100, 0,      0, 0, 4'h0, 0,      0,          0, 0, 1, 1, 0, 0, 0,            0);
        tbl[12] = mk(0, 1, 4'h0, 32'h100, 0,      0, 0, 4'h0, 0,      0,          1, 0, 0, 0, 0, 0, 0,            0);
        tbl[13] = mk(0, 0, 4'h0, 32'h100, 0,      0, 0, 4'h0, 0,      0,          0, 0, 0, 0, 1, 0, 32'h12345678, 0);

        // Bring the DUT out of an unknown state before checking anything.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                  tbl[i].dr, tbl[i].dl, tbl[i].dw, tbl[i].da, tbl[i].dd);
            pre();
            chk($sformatf("t%0d_cpu_gnt", i),    cpu_gnt,    tbl[i].ecg);
            chk($sformatf("t%0d_dbg_gnt", i),    dbg_gnt,    tbl[i].edg);
            chk($sformatf("t%0d_cpu_stall", i),  cpu_stall,  tbl[i].est);
            chk($sformatf("t%0d_locked", i),     locked,     tbl[i].elk);
            chk($sformatf("t%0d_cpu_rvalid", i), cpu_rvalid, tbl[i].ecrv);
            chk($sformatf("t%0d_dbg_rvalid", i), dbg_rvalid, tbl[i].edrv);
            chk($sformatf("t%0d_cpu_rdata", i),  cpu_rdata,  tbl[i].ecrd);
            chk($sformatf("t%0d_dbg_rdata", i),  dbg_rdata,  tbl[i].edrd);
            if (tbl[i].r) chk($sformatf("t%0d_web_rst", i), web, 4'h0);
            post();
        end

        // Contention: DBG wins every 9th cycle.
        drive(0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h4, 0);
        for (int c = 1; c <= 27; c++) begin
            pre();
            chk($sformatf("cont%0d_dbg_gnt", c),   dbg_gnt,   (c % 9) == 0);
            chk($sformatf("cont%0d_cpu_stall", c), cpu_stall, (c % 9) == 0);
            post();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre(); post();

        // Locked burst of three DBG writes with the CPU requesting throughout.
        wd[0] = 32'hA0A0_0001; wd[1] = 32'hB1B1_0002; wd[2] = 32'hC2C2_0003;
        for (int i = 0; i < 11; i++) begin
            int k;
            k = (i < 8) ? 0 : i - 8;
            drive(0, 1, 0, 32'h200, 0, 1, 1, 4'hF, 32'(4 * k), wd[k]);
            pre();
            chk($sformatf("lock%0d_dbg_gnt", i), dbg_gnt, i >= 8);
            chk($sformatf("lock%0d_cpu_gnt", i), cpu_gnt, i < 8);
            chk($sformatf("lock%0d_locked", i),  locked,  i >= 9);
            post();
        end
        drive(0, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0);
        pre();
        chk("lock_fall_cpu_gnt", cpu_gnt, 1'b0);
        chk("lock_fall_locked",  locked,  1'b1);
        post();
        for (int i = 0; i < 4; i++) begin
            drive(0, i < 3, 0, 32'(4 * i), 0, 0, 0, 0, 0, 0);
            pre();
            if (i == 0) begin
                chk("unlock_cpu_gnt", cpu_gnt, 1'b1);
                chk("unlock_locked",  locked,  1'b0);
            end else begin
                chk($sformatf("burst_rd%0d_valid", i - 1), cpu_rvalid, 1'b1);
                chk($sformatf("burst_rd%0d_data", i - 1),  cpu_rdata,  wd[i - 1]);
            end
            post();
        end

        // Partial store then read-back of the merged word.
        drive(0, 1, 4'b0011, 32'h22, 32'h0000_BEEF, 0, 0, 0, 0, 0);
        pre();
        chk("st_cpu_gnt", cpu_gnt, 1'b1);
        chk("st_web",     web,     4'b0011);
        post();
        drive(0, 1, 4'b0000, 32'h20, 0, 0, 0, 0, 0, 0);
        pre();
        chk("st_no_rvalid", cpu_rvalid, 1'b0);
        post();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre();
        chk("st_merge_valid", cpu_rvalid, 1'b1);
        chk("st_merge_data",  cpu_rdata,  32'h1122_BEEF);
        post();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  32'($urandom_range(0, 1023)), $urandom,
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  32'($urandom_range(0, 1023)), $urandom);
            pre();
            post();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
